// File: rtl/idct_pkg.sv
// idct_pkg: shared types and constants for the 8x8 inverse DCT.
//   state_e     : controller states LOAD / ROW / OUT
//   BLOCK_SIZE  : samples per 8x8 block
//   TAPS        : terms per dot product (one row/column of the block)
//   basis()     : cosine basis constant M[k][n] scaled by 2^(coef_width-1)
package idct_pkg;

  localparam int unsigned BLOCK_SIZE = 64;
  localparam int unsigned TAPS       = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ROW  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // cos(j*pi/16) for j = 0..8 in Q30; only elaboration-time constant calls.
  function automatic longint cos_q30(input int unsigned j);
    case (j)
      0:       return 64'sd1073741824;
      1:       return 64'sd1053110176;
      2:       return 64'sd992008094;
      3:       return 64'sd892783698;
      4:       return 64'sd759250125;
      5:       return 64'sd596538995;
      6:       return 64'sd410903207;
      7:       return 64'sd209476638;
      default: return 64'sd0;
    endcase
  endfunction

  // round(cos((2n+1)k*pi/16) * 2^(coef_width-1)); row k=0 uses cos(pi/4).
  // The angle is folded into [0, pi/2] so only the Q30 table above is needed.
  function automatic int basis(input int unsigned k, input int unsigned n,
                               input int unsigned coef_width);
    int unsigned a;
    logic        neg;
    longint      mag;
    a   = (k == 0) ? 32'd4 : ((2 * n + 1) * k) % 32;
    neg = 1'b0;
    if (a > 16) a = 32 - a;
    if (a > 8) begin
      a   = 16 - a;
      neg = 1'b1;
    end
    mag = ((cos_q30(a) <<< (coef_width - 1)) + (64'sd1 <<< 29)) >>> 30;
    return neg ? -32'(mag) : 32'(mag);
  endfunction

endpackage

// File: rtl/idct_dot8.sv
// idct_dot8: 8-term signed multiply-accumulate, arithmetic shift by COEF_W,
// result wrapped to OUT_W and registered (one cycle latency, hold when !en).
// Shared by the row and column passes of idct_2d.
// Optional feature macro: IDCT_ROUND_EN adds 2^(COEF_W-1) before the shift.
//   clk, rst : clock, synchronous active-high reset (clears res_q)
//   en       : capture a new result
//   a_i      : 8 signed data operands
//   m_i      : 8 signed basis constants
//   res_q    : registered result
module idct_dot8
  import idct_pkg::*;
#(
  parameter int unsigned IN_W   = 11,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 22,
  parameter int unsigned OUT_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [IN_W-1:0]   a_i [TAPS],
  input  logic signed [COEF_W-1:0] m_i [TAPS],
  output logic signed [OUT_W-1:0]  res_q
);

`ifdef IDCT_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_W - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  logic signed [ACC_W-1:0] acc_c;
  logic signed [OUT_W-1:0] res_d;

  // Full-precision sum of products, then shift and wrap.
  always_comb begin
    acc_c = RND;
    for (int i = 0; i < TAPS; i++) begin
      acc_c = acc_c + ACC_W'(a_i[i]) * ACC_W'(m_i[i]);
    end
    res_d = en ? OUT_W'(acc_c >>> COEF_W) : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

endmodule

// File: rtl/idct_2d.sv
// idct_2d: 8x8 two-dimensional inverse DCT with valid/ready streaming.
// Loads 64 coefficients (row-major), runs a 64-cycle row pass into the
// t buffer, then produces 64 output samples on demand (column pass).
// Optional feature macro: IDCT_ROUND_EN (round-half-up in both passes).
//   clk, rst         : clock, synchronous active-high reset
//   x_valid/x_ready  : input handshake, x_data = signed X[v][u]
//   y_valid/y_ready  : output handshake, y_data = signed y[r][c]
//   y_last           : marks the 64th output beat of a block
module idct_2d
  import idct_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned COEF_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_ready,
  output logic                  y_valid,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_last,
  input  logic                  y_ready
);

  localparam int unsigned T_W      = DATA_WIDTH + 3;
  localparam int unsigned ACC_W    = DATA_WIDTH + COEF_WIDTH + 6;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned ROW_W    = 7;
  // Row pass: issue in cycles 0..63, last write-back in 64, handover in 65.
  localparam int unsigned ROW_DONE = BLOCK_SIZE + 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    all_issued_q, all_issued_d;
  logic                    x_ready_q, x_ready_d;
  logic                    y_valid_q, y_valid_d;
  logic                    y_last_q, y_last_d;

  // Input banks indexed by u, t banks indexed by v: 8 operands per cycle.
  logic signed [DATA_WIDTH-1:0] xbuf_q [TAPS][TAPS];
  logic signed [T_W-1:0]        tbuf_q [TAPS][TAPS];
  logic signed [COEF_WIDTH-1:0] mtab   [TAPS][TAPS];

  logic                    x_we_c;
  logic                    t_we_c;
  logic [CNT_W-1:0]        t_waddr_c;
  logic                    dot_en_c;
  logic signed [T_W-1:0]        a_c [TAPS];
  logic signed [COEF_WIDTH-1:0] m_c [TAPS];
  logic signed [T_W-1:0]        dot_res;

  // Constant basis table M[k][n].
  for (genvar k = 0; k < TAPS; k++) begin : g_k
    for (genvar n = 0; n < TAPS; n++) begin : g_n
      assign mtab[k][n] = COEF_WIDTH'(basis(k, n, COEF_WIDTH));
    end
  end

  // Next-state, counters, operand selection and output registers.
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    row_cnt_d    = row_cnt_q;
    out_cnt_d    = out_cnt_q;
    all_issued_d = all_issued_q;
    y_valid_d    = y_valid_q;
    y_last_d     = y_last_q;
    x_we_c       = 1'b0;
    t_we_c       = 1'b0;
    t_waddr_c    = CNT_W'(row_cnt_q - ROW_W'(1));
    dot_en_c     = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      a_c[i] = '0;
      m_c[i] = '0;
    end

    case (state_q)
      LOAD: begin
        if (x_valid && x_ready_q) begin
          x_we_c   = 1'b1;
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
            state_d   = ROW;
            row_cnt_d = '0;
          end
        end
      end

      ROW: begin
        row_cnt_d = row_cnt_q + ROW_W'(1);
        // t[v][n]: row v of X against basis column n.
        if (row_cnt_q < ROW_W'(BLOCK_SIZE)) begin
          dot_en_c = 1'b1;
          for (int i = 0; i < TAPS; i++) begin
            a_c[i] = T_W'(xbuf_q[i][row_cnt_q[5:3]]);
            m_c[i] = mtab[i][row_cnt_q[2:0]];
          end
        end
        // Result of issue i lands one cycle later.
        if (row_cnt_q != '0 && row_cnt_q <= ROW_W'(BLOCK_SIZE)) t_we_c = 1'b1;
        if (row_cnt_q == ROW_W'(ROW_DONE)) begin
          state_d      = OUT;
          out_cnt_d    = '0;
          all_issued_d = 1'b0;
        end
      end

      OUT: begin
        // Compute the next sample whenever the output register is free.
        if (!all_issued_q && (!y_valid_q || y_ready)) begin
          dot_en_c  = 1'b1;
          for (int i = 0; i < TAPS; i++) begin
            a_c[i] = tbuf_q[i][out_cnt_q[2:0]];
            m_c[i] = mtab[i][out_cnt_q[5:3]];
          end
          y_valid_d = 1'b1;
          y_last_d  = (out_cnt_q == CNT_W'(BLOCK_SIZE - 1));
          out_cnt_d = out_cnt_q + CNT_W'(1);
          if (out_cnt_q == CNT_W'(BLOCK_SIZE - 1)) all_issued_d = 1'b1;
        end else if (y_valid_q && y_ready) begin
          y_valid_d = 1'b0;
          y_last_d  = 1'b0;
          if (y_last_q) state_d = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase

    x_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      in_cnt_q     <= '0;
      row_cnt_q    <= '0;
      out_cnt_q    <= '0;
      all_issued_q <= 1'b0;
      x_ready_q    <= 1'b0;
      y_valid_q    <= 1'b0;
      y_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      row_cnt_q    <= row_cnt_d;
      out_cnt_q    <= out_cnt_d;
      all_issued_q <= all_issued_d;
      x_ready_q    <= x_ready_d;
      y_valid_q    <= y_valid_d;
      y_last_q     <= y_last_d;
    end
  end

  // Buffer writes; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && x_we_c) xbuf_q[in_cnt_q[2:0]][in_cnt_q[5:3]] <= x_data;
    if (!rst && t_we_c) tbuf_q[t_waddr_c[5:3]][t_waddr_c[2:0]] <= dot_res;
  end

  idct_dot8 #(
    .IN_W  (T_W),
    .COEF_W(COEF_WIDTH),
    .ACC_W (ACC_W),
    .OUT_W (T_W)
  ) u_dot8 (
    .clk  (clk),
    .rst  (rst),
    .en   (dot_en_c),
    .a_i  (a_c),
    .m_i  (m_c),
    .res_q(dot_res)
  );

  assign x_ready = x_ready_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;
  // Column results wrap to the low DATA_WIDTH bits.
  assign y_data  = dot_res[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_idct_2d.sv
// tb_idct_2d: directed self-checking bench for idct_2d (default parameters).
// Expected data comes from hand-computed constants (zero block, DC block)
// and an independent floating-point-derived basis model for random blocks.
// Honours IDCT_ROUND_EN the same way the design does.
module tb_idct_2d;

`ifdef IDCT_ROUND_EN
  localparam int     DC_EXP = 8;
  localparam longint RND    = 128;
`else
  localparam int     DC_EXP = 7;
  localparam longint RND    = 0;
`endif

  logic              clk;
  logic              rst;
  logic              x_valid;
  logic signed [7:0] x_data;
  logic              x_ready;
  logic              y_valid;
  logic signed [7:0] y_data;
  logic              y_last;
  logic              y_ready;

  int errors = 0;
  int checks = 0;

  logic signed [7:0] xin   [64];
  int                exp_y [64];
  int                got   [64];
  int                mb    [8][8];

  idct_2d dut (
    .clk    (clk),
    .rst    (rst),
    .x_valid(x_valid),
    .x_data (x_data),
    .x_ready(x_ready),
    .y_valid(y_valid),
    .y_data (y_data),
    .y_last (y_last),
    .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic init_basis();
    real pi, c;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        c = (k == 0) ? $cos(pi / 4.0) : $cos(real'((2 * n + 1) * k) * pi / 16.0);
        mb[k][n] = int'($floor(c * 128.0 + 0.5));
      end
    end
  endtask

  // Bit-exact reference: row pass wrapped to 11 bits, column pass to 8 bits.
  task automatic run_model();
    longint            acc;
    logic signed [10:0] t [8][8];
    logic signed [7:0]  yv;
    for (int v = 0; v < 8; v++) begin
      for (int n = 0; n < 8; n++) begin
        acc = RND;
        for (int u = 0; u < 8; u++) acc += longint'(mb[u][n]) * longint'(xin[v * 8 + u]);
        t[v][n] = 11'(acc >>> 8);
      end
    end
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        acc = RND;
        for (int v = 0; v < 8; v++) acc += longint'(mb[v][r]) * longint'(t[v][c]);
        yv = 8'(acc >>> 8);
        exp_y[r * 8 + c] = int'(yv);
      end
    end
  endtask

  task automatic drive_block(input string name, input int n);
    int   bi;
    logic xr;
    bi      = 0;
    x_valid = 1'b1;
    for (int cyc = 0; cyc < 2000 && bi < n; cyc++) begin
      x_data = xin[bi];
      xr     = x_ready;
      @(posedge clk); #1;
      if (xr === 1'b1) bi++;
    end
    check({name, "_in_beats"}, bi, n);
    x_data = 8'($urandom);
  endtask

  // Full block: load, latency, collect (optional 10-cycle stall), compare.
  task automatic run_block(input string name, input int stall_at);
    int                lat, nb, stall, bubbles, last_err, stable_err, xr_err;
    logic signed [7:0] held;
    drive_block(name, 64);
    lat    = 0;
    xr_err = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      lat++;
      if (x_ready !== 1'b0) xr_err++;
      if (y_valid === 1'b1) break;
    end
    check({name, "_latency"}, lat, 67);
    nb = 0; stall = 0; bubbles = 0; last_err = 0; stable_err = 0;
    held = '0;
    for (int cyc = 0; cyc < 400 && nb < 64; cyc++) begin
      if (x_ready !== 1'b0) xr_err++;
      if (y_valid !== 1'b1) begin
        bubbles++;
        y_ready = 1'b1;
      end else if (nb == stall_at && stall < 10) begin
        if (stall == 0) held = y_data;
        else if (y_data !== held) stable_err++;
        y_ready = 1'b0;
        stall++;
      end else begin
        if (stall_at >= 0 && nb == stall_at && y_data !== held) stable_err++;
        y_ready = 1'b1;
        got[nb] = int'(y_data);
        if (y_last !== (nb == 63)) last_err++;
        nb++;
      end
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    check({name, "_out_beats"}, nb, 64);
    check({name, "_bubbles"}, bubbles, 0);
    check({name, "_y_last_pos"}, last_err, 0);
    check({name, "_x_ready_busy"}, xr_err, 0);
    if (stall_at >= 0) begin
      check({name, "_stall_cycles"}, stall, 10);
      check({name, "_stall_stable"}, stable_err, 0);
    end
    check({name, "_x_ready_next"}, x_ready, 1);
    check({name, "_y_valid_idle"}, y_valid, 0);
    for (int i = 0; i < nb; i++) check($sformatf("%s_beat%0d", name, i), got[i], exp_y[i]);
  endtask

  initial begin
    rst     = 1'b1;
    x_valid = 1'b0;
    x_data  = '0;
    y_ready = 1'b0;
    init_basis();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_ready", x_ready, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_last", y_last, 0);
    check("rst_y_data", y_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("x_ready_after_rst", x_ready, 1);
    y_ready = 1'b1;

    // All-zero block
    for (int i = 0; i < 64; i++) begin
      xin[i]   = '0;
      exp_y[i] = 0;
    end
    run_block("zero", -1);

    // DC only, with a 10-cycle stall at output beat 5
    for (int i = 0; i < 64; i++) begin
      xin[i]   = '0;
      exp_y[i] = DC_EXP;
    end
    xin[0] = 8'sd64;
    run_block("dc_stall", 5);

    // Non-uniform block with the same stall, so duplicated/lost beats show
    for (int i = 0; i < 64; i++) xin[i] = 8'($urandom_range(0, 255));
    run_model();
    run_block("rand_stall", 5);

    // Partial block interrupted by reset, then a clean DC block
    for (int i = 0; i < 64; i++) xin[i] = 8'sd100 - 8'(i);
    drive_block("partial", 30);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midload_rst_x_ready", x_ready, 0);
    check("midload_rst_y_valid", y_valid, 0);
    check("midload_rst_y_data", y_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midload_x_ready_rise", x_ready, 1);
    for (int i = 0; i < 64; i++) begin
      xin[i]   = '0;
      exp_y[i] = DC_EXP;
    end
    xin[0] = 8'sd64;
    run_block("dc_after_rst", -1);

    // Two back-to-back random blocks, x_valid and y_ready held high
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) xin[i] = 8'($urandom_range(0, 255));
      run_model();
      run_block($sformatf("b2b%0d", b), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
